count_seq_checker: RTL and testbench



---
 rtl/count_seq_checker_if.sv | 41 ++++
 rtl/count_seq_checker.sv | 175 +++++++++++++++++
 tb/tb_count_seq_checker.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/count_seq_checker_if.sv
// Sample and statistics bundle between an up-counter source and count_seq_checker.
// The capture signals exist only when COUNT_SEQ_CHECKER_CAPTURE_EN is defined.
interface count_seq_checker_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] count_in;
  logic             clear;
  logic             locked;
  logic             error_pulse;
  logic             error_sticky;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] cap_expected;
  logic [WIDTH-1:0] cap_actual;

  modport master (
    output in_valid, count_in, clear,
    input  locked, error_pulse, error_sticky, err_count, wrap_count,
    input  cap_expected, cap_actual
  );

  modport slave (
    input  in_valid, count_in, clear,
    output locked, error_pulse, error_sticky, err_count, wrap_count,
    output cap_expected, cap_actual
  );
`else
  modport master (
    output in_valid, count_in, clear,
    input  locked, error_pulse, error_sticky, err_count, wrap_count
  );

  modport slave (
    input  in_valid, count_in, clear,
    output locked, error_pulse, error_sticky, err_count, wrap_count
  );
`endif
endinterface

// File: rtl/count_seq_checker.sv
// Locks onto an incrementing count stream and flags any sample that is not previous+1.
// Define COUNT_SEQ_CHECKER_CAPTURE_EN to latch expected/actual of the first locked mismatch.
module count_seq_checker #(
  parameter int WIDTH    = 5,
  parameter int CNT_W    = 8,
  parameter int LOCK_LEN = 2
) (
  input  logic               clk,
  input  logic               reset,
  count_seq_checker_if.slave mon
);
  localparam int MATCH_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_expected;
  logic [WIDTH-1:0]   w_expected_next;
  logic [MATCH_W-1:0] r_match_cnt;
  logic [MATCH_W-1:0] w_match_cnt_next;
  logic               r_locked;
  logic               r_error_pulse;
  logic               w_error_pulse_next;
  logic               r_error_sticky;
  logic               w_error_sticky_next;
  logic [CNT_W-1:0]   r_err_count;
  logic [CNT_W-1:0]   w_err_count_next;
  logic [CNT_W-1:0]   r_wrap_count;
  logic [CNT_W-1:0]   w_wrap_count_next;

  logic               w_hit;
  logic               w_locked_miss;
  logic [WIDTH-1:0]   w_count_plus1;
  logic [MATCH_W-1:0] w_match_inc;
  logic [CNT_W-1:0]   w_err_count_inc;
  logic [CNT_W-1:0]   w_wrap_count_inc;

  assign w_hit         = (mon.count_in == r_expected);
  assign w_count_plus1 = mon.count_in + WIDTH'(1);
  assign w_match_inc   = r_match_cnt + MATCH_W'(1);
  assign w_locked_miss = mon.in_valid && (r_state == ST_LOCKED) && !w_hit;

  // Statistics saturate at all-ones instead of rolling over.
  assign w_err_count_inc  = (r_err_count == {CNT_W{1'b1}}) ? r_err_count
                                                           : r_err_count + CNT_W'(1);
  assign w_wrap_count_inc = (r_wrap_count == {CNT_W{1'b1}}) ? r_wrap_count
                                                            : r_wrap_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_expected     <= '0;
      r_match_cnt    <= '0;
      r_locked       <= 1'b0;
      r_error_pulse  <= 1'b0;
      r_error_sticky <= 1'b0;
      r_err_count    <= '0;
      r_wrap_count   <= '0;
    end else begin
      r_state        <= w_state_next;
      r_expected     <= w_expected_next;
      r_match_cnt    <= w_match_cnt_next;
      r_locked       <= (w_state_next == ST_LOCKED);
      r_error_pulse  <= w_error_pulse_next;
      r_error_sticky <= w_error_sticky_next;
      r_err_count    <= w_err_count_next;
      r_wrap_count   <= w_wrap_count_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_expected_next     = r_expected;
    w_match_cnt_next    = r_match_cnt;
    w_error_pulse_next  = 1'b0;
    w_error_sticky_next = r_error_sticky;
    w_err_count_next    = r_err_count;
    w_wrap_count_next   = r_wrap_count;

    if (mon.in_valid) begin
      w_expected_next = w_count_plus1;
      case (r_state)
        ST_IDLE: begin
          w_state_next     = ST_ACQUIRE;
          w_match_cnt_next = '0;
        end
        ST_ACQUIRE: begin
          if (w_hit) begin
            if (w_match_inc == MATCH_W'(LOCK_LEN)) begin
              w_state_next     = ST_LOCKED;
              w_match_cnt_next = '0;
            end else begin
              w_match_cnt_next = w_match_inc;
            end
          end else begin
            w_match_cnt_next = '0;
          end
        end
        ST_LOCKED: begin
          if (w_hit) begin
            if (mon.count_in == '0) begin
              w_wrap_count_next = w_wrap_count_inc;
            end
          end else begin
            w_state_next        = ST_ACQUIRE;
            w_match_cnt_next    = '0;
            w_error_pulse_next  = 1'b1;
            w_error_sticky_next = 1'b1;
            w_err_count_next    = w_err_count_inc;
          end
        end
        default: begin
          w_state_next     = ST_IDLE;
          w_match_cnt_next = '0;
        end
      endcase
    end

    // Clearing statistics overrides a same-cycle update, but the pulse still fires.
    if (mon.clear) begin
      w_error_sticky_next = 1'b0;
      w_err_count_next    = '0;
      w_wrap_count_next   = '0;
    end
  end

  assign mon.locked       = r_locked;
  assign mon.error_pulse  = r_error_pulse;
  assign mon.error_sticky = r_error_sticky;
  assign mon.err_count    = r_err_count;
  assign mon.wrap_count   = r_wrap_count;

`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] r_cap_expected;
  logic [WIDTH-1:0] r_cap_actual;
  logic [WIDTH-1:0] w_cap_expected_next;
  logic [WIDTH-1:0] w_cap_actual_next;

  // Only the first locked mismatch since reset/clear is kept (sticky not yet set).
  always_comb begin
    w_cap_expected_next = r_cap_expected;
    w_cap_actual_next   = r_cap_actual;
    if (w_locked_miss && !r_error_sticky) begin
      w_cap_expected_next = r_expected;
      w_cap_actual_next   = mon.count_in;
    end
    if (mon.clear) begin
      w_cap_expected_next = '0;
      w_cap_actual_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_expected <= '0;
      r_cap_actual   <= '0;
    end else begin
      r_cap_expected <= w_cap_expected_next;
      r_cap_actual   <= w_cap_actual_next;
    end
  end

  assign mon.cap_expected = r_cap_expected;
  assign mon.cap_actual   = r_cap_actual;
`else
  logic w_unused;
  assign w_unused = w_locked_miss;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: a history-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_count_seq_checker;
  localparam int W        = 5;
  localparam int CW       = 8;
  localparam int LOCK_LEN = 2;
  localparam int MODV     = 1 << W;
  localparam int CMAX     = (1 << CW) - 1;

  logic clk;
  logic reset;

  count_seq_checker_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  count_seq_checker #(.WIDTH(W), .CNT_W(CW), .LOCK_LEN(LOCK_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: remembers the last sample and how many correct increments followed it.
  bit m_have_prev, m_locked, m_pulse, m_sticky;
  int m_prev, m_run, m_err, m_wrap, m_cap_exp, m_cap_act;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit v, input int d, input bit clr);
    bit ok;
    if (rst) begin
      m_have_prev = 0; m_locked = 0; m_pulse = 0; m_sticky = 0;
      m_prev = 0; m_run = 0; m_err = 0; m_wrap = 0; m_cap_exp = 0; m_cap_act = 0;
      return;
    end
    m_pulse = 0;
    if (v) begin
      if (!m_have_prev) begin
        m_have_prev = 1;
        m_run = 0;
      end else begin
        ok = (d == (m_prev + 1) % MODV);
        if (m_locked) begin
          if (ok) begin
            if (d == 0 && m_wrap < CMAX) m_wrap++;
          end else begin
            m_pulse = 1;
            if (!m_sticky) begin
              m_cap_exp = (m_prev + 1) % MODV;
              m_cap_act = d;
            end
            m_sticky = 1;
            if (m_err < CMAX) m_err++;
            m_locked = 0;
            m_run = 0;
          end
        end else if (ok) begin
          m_run++;
          if (m_run >= LOCK_LEN) m_locked = 1;
        end else begin
          m_run = 0;
        end
      end
      m_prev = d;
    end
    if (clr) begin
      m_err = 0; m_wrap = 0; m_sticky = 0; m_cap_exp = 0; m_cap_act = 0;
    end
  endtask

  task automatic step(input bit rst, input bit v, input int d, input bit clr);
    int dm;
    dm = d % MODV;
    reset        = rst;
    bus.in_valid = v;
    bus.count_in = W'(dm);
    bus.clear    = clr;
    @(posedge clk);
    model_update(rst, v, dm, clr);
    @(negedge clk);
    $display("[TB] t=%0t rst=%0d v=%0d d=%0d clr=%0d -> locked=%0d pulse=%0d sticky=%0d err=%0d wrap=%0d",
             $time, rst, v, dm, clr, bus.locked, bus.error_pulse, bus.error_sticky,
             bus.err_count, bus.wrap_count);
  endtask

  task automatic feed(input int d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 1'b0);
  endtask

  // Compare process: every cycle after the first reset edge, DUT against model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("locked",       int'(bus.locked),       int'(m_locked));
      check("error_pulse",  int'(bus.error_pulse),  int'(m_pulse));
      check("error_sticky", int'(bus.error_sticky), int'(m_sticky));
      check("err_count",    int'(bus.err_count),    m_err);
      check("wrap_count",   int'(bus.wrap_count),   m_wrap);
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
      check("cap_expected", int'(bus.cap_expected), m_cap_exp);
      check("cap_actual",   int'(bus.cap_actual),   m_cap_act);
`endif
    end
  end

  initial begin
    int cur;
    reset = 1'b1; bus.in_valid = 1'b0; bus.count_in = '0; bus.clear = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 0, 1'b0);
      chk_en = 1'b1;
    end
    check("lit_reset_locked", int'(bus.locked), 0);
    check("lit_reset_err",    int'(bus.err_count), 0);

    // Acquire on 0,1,2: lock visible after sample 2.
    feed(0);
    feed(1);
    check("lit_not_locked_after_1", int'(bus.locked), 0);
    feed(2);
    check("lit_locked_after_2", int'(bus.locked), 1);

    // Run through 31 and a full second lap: exactly one wrap.
    for (int i = 3; i < 32; i++) feed(i);
    for (int i = 0; i < 32; i++) feed(i);
    check("lit_wrap_one",   int'(bus.wrap_count), 1);
    check("lit_sticky_low", int'(bus.error_sticky), 0);
    check("lit_err_zero",   int'(bus.err_count), 0);

    // 5,6,9 while locked: one error, capture 7 vs 9.
    for (int i = 0; i < 7; i++) feed(i);
    feed(9);
    check("lit_err_pulse",  int'(bus.error_pulse), 1);
    check("lit_err_one",    int'(bus.err_count), 1);
    check("lit_sticky_set", int'(bus.error_sticky), 1);
    check("lit_unlocked",   int'(bus.locked), 0);
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    check("lit_cap_expected", int'(bus.cap_expected), 7);
    check("lit_cap_actual",   int'(bus.cap_actual), 9);
`endif
    idle();
    check("lit_pulse_one_cycle", int'(bus.error_pulse), 0);
    feed(10);
    feed(11);
    check("lit_relocked", int'(bus.locked), 1);

    // Clear, then a stalled counter: one error only.
    step(1'b0, 1'b0, 0, 1'b1);
    check("lit_clear_err",    int'(bus.err_count), 0);
    check("lit_clear_locked", int'(bus.locked), 1);
    for (int i = 0; i < 4; i++) feed(4);
    check("lit_stall_err", int'(bus.err_count), 1);
    check("lit_stall_unlocked", int'(bus.locked), 0);

    // Correct sequence with valid gaps: relocks, no new errors.
    feed(5); idle(); feed(6); idle(); idle(); feed(7); feed(8); idle();
    for (int i = 9; i <= 20; i++) begin
      feed(i);
      if (i % 3 == 0) idle();
    end
    check("lit_gap_err",    int'(bus.err_count), 1);
    check("lit_gap_locked", int'(bus.locked), 1);

    // Clear coincident with a mismatch: counters/sticky cleared, pulse still fires.
    step(1'b0, 1'b1, 25, 1'b1);
    check("lit_clrmiss_pulse",  int'(bus.error_pulse), 1);
    check("lit_clrmiss_err",    int'(bus.err_count), 0);
    check("lit_clrmiss_sticky", int'(bus.error_sticky), 0);

    // 260 lock/miss cycles: err_count must saturate at 255.
    cur = 25;
    for (int k = 0; k < 260; k++) begin
      feed(cur + 1);
      feed(cur + 2);
      feed(cur + 7);
      cur = (cur + 7) % MODV;
    end
    check("lit_err_saturated", int'(bus.err_count), CMAX);

    // Relock, run to 31, then clear together with the wrap.
    feed(cur + 1);
    feed(cur + 2);
    cur = (cur + 2) % MODV;
    while (cur != 31) begin
      cur++;
      feed(cur);
    end
    step(1'b0, 1'b1, 0, 1'b1);
    check("lit_clrwrap_wrap",   int'(bus.wrap_count), 0);
    check("lit_clrwrap_locked", int'(bus.locked), 1);

    // Reset mid-lock with a bad sample present: everything zero, then re-acquire.
    step(1'b1, 1'b1, 7, 1'b0);
    check("lit_rst_locked", int'(bus.locked), 0);
    check("lit_rst_err",    int'(bus.err_count), 0);
    check("lit_rst_pulse",  int'(bus.error_pulse), 0);
    feed(20);
    feed(21);
    check("lit_rst_acq", int'(bus.locked), 0);
    feed(22);
    check("lit_rst_relock", int'(bus.locked), 1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
